dport_responder: RTL and testbench
==================================

Name: dport_responder

Overview:
CPU-side responder for the debug-port (dport) request/response channel that the debug module drives when it executes abstract register-access commands.
- Accepts one request at a time and decodes the debug-spec regno into GPR or CSR space.
- Performs the access through the integer register file write/read port or the CSR unit handshake.
- Returns read data and an error flag.
- Sits inside the processor core, between the dport interface and the regfile/CSR units.

Parameters:
RISCV_ARCH, 64, data width of wdata/rdata and of regfile/CSR data ports
CSR_TIMEOUT, 255, cycles to wait for CSR request accept or response before returning an error (8-bit counter)

Ports:
i_clk  in  1  clock
i_nrst  in  1  reset, asynchronous, active-low
i_dport_req_valid  in  1  request valid
o_dport_req_ready  out  1  request accepted when valid&ready
i_dport_write  in  1  1 = write, 0 = read
i_dport_addr  in  16  regno: 0x0000-0x0FFF CSR, 0x1000-0x101F GPR x0..x31, all else unsupported
i_dport_wdata  in  RISCV_ARCH  write data
i_dport_size  in  3  2 = 32-bit, 3 = 64-bit, others illegal
o_dport_resp_valid  out  1  response valid
i_dport_resp_ready  in  1  response consumed when valid&ready
o_dport_resp_error  out  1  access failed
o_dport_rdata  out  RISCV_ARCH  read data
i_halted  in  1  hart halted
o_ireg_addr  out  5  regfile index
o_ireg_wena  out  1  regfile write strobe, 1 cycle
o_ireg_wdata  out  RISCV_ARCH  regfile write data
i_ireg_rdata  in  RISCV_ARCH  regfile read data, combinational on o_ireg_addr
o_csr_req_valid  out  1  CSR request valid
i_csr_req_ready  in  1  CSR request accepted
o_csr_req_write  out  1  CSR write
o_csr_req_addr  out  12  CSR index
o_csr_req_data  out  RISCV_ARCH  CSR write data
i_csr_resp_valid  in  1  CSR response valid
o_csr_resp_ready  out  1  CSR response ready, held 1 in CSR_RESP
i_csr_resp_data  in  RISCV_ARCH  CSR read data
i_csr_resp_exception  in  1  CSR access faulted

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0. o_dport_req_ready becomes 1 in IDLE once reset deasserts.
- IDLE:
  - req_ready = 1.
  - On valid&ready, latch write, addr, wdata and size.
  - For size 2, the latched wdata is zero-extended from [31:0].
  - Go to CHECK.
- CHECK (1 cycle), error priority:
  1. size not 2/3 → error.
  2. !i_halted → error.
  3. addr not in CSR/GPR range → error.
  - Error → RESP with error = 1, rdata = 0.
  - GPR → GPR state.
  - CSR → CSR_REQ, counter cleared.
- GPR (1 cycle):
  - o_ireg_addr = addr[4:0].
  - Write: o_ireg_wena = 1 unless index 0; writes to x0 are silently dropped with error = 0.
  - Read: capture i_ireg_rdata.
  - Go to RESP.
- CSR_REQ:
  - Assert o_csr_req_valid with write/addr[11:0]/data; hold until i_csr_req_ready, then go to CSR_RESP and clear the counter.
  - Counter increments each waiting cycle. Reaching CSR_TIMEOUT → RESP with error = 1 and valid dropped.
- CSR_RESP:
  - o_csr_resp_ready = 1.
  - On i_csr_resp_valid: capture data (reads only); error = i_csr_resp_exception; go to RESP.
  - Same timeout rule as CSR_REQ.
- RESP:
  - o_dport_resp_valid = 1, with rdata/error stable.
  - On i_dport_resp_ready, return to IDLE; the next request can be accepted on the following cycle.
- Read data:
  - Size 2 returns the low 32 bits zero-extended.
  - Writes return rdata = 0.
- Latency, acceptance at cycle N, zero backpressure: error at N+2; GPR at N+3; CSR with same-cycle ready and response-next-cycle at N+4.
- Requests are not accepted outside IDLE; there is at most one outstanding request.
- Changes to i_halted after CHECK are ignored for the current request.
- Asynchronous reset mid-operation returns to IDLE with all strobes deasserted. The request in flight is discarded with no response.

Test Plan:
- Halted, write x5 = 0x1122334455667788 size 3 (addr 0x1005), then read addr 0x1005 → o_ireg_wena pulse addr 5; read rdata 0x1122334455667788, error 0, resp_valid at N+3.
- Write x0 = 0xFF then read x0 with regfile modelled as zero → no wena pulse, error 0, read returns 0.
- Read CSR 0x7B1 size 2, CSR model returns 0xDEADBEEF_CAFEF00D after a 3-cycle ready stall → o_csr_req_addr 0x7B1 held during the stall; rdata 0x00000000CAFEF00D, error 0.
- Error cases → each error 1, rdata 0, no regfile/CSR strobe:
  - i_halted = 0 with read of 0x1001.
  - size = 1.
  - addr 0x1020 (FPR).
- CSR model never asserts resp_valid → error response after CSR_TIMEOUT (255) cycles in CSR_RESP; then IDLE, and a subsequent GPR read succeeds.
- Hold i_dport_resp_ready = 0 for 10 cycles in RESP with a new req_valid pending → rdata/error stable, req_ready 0; after the handshake the pending request is accepted one cycle later. Separately, assert i_nrst low during CSR_REQ → o_csr_req_valid and o_dport_resp_valid drop immediately to 0.

Source files
------------

// File: rtl/dport_responder.sv
// Debug-port responder: decodes abstract register-access requests into GPR or CSR
// accesses and returns read data with an error flag. One request in flight at a time.
module dport_responder #(
  parameter int RISCV_ARCH  = 64,
  parameter int CSR_TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_dport_req_valid,
  output logic                  o_dport_req_ready,
  input  logic                  i_dport_write,
  input  logic [15:0]           i_dport_addr,
  input  logic [RISCV_ARCH-1:0] i_dport_wdata,
  input  logic [2:0]            i_dport_size,
  output logic                  o_dport_resp_valid,
  input  logic                  i_dport_resp_ready,
  output logic                  o_dport_resp_error,
  output logic [RISCV_ARCH-1:0] o_dport_rdata,
  input  logic                  i_halted,
  output logic [4:0]            o_ireg_addr,
  output logic                  o_ireg_wena,
  output logic [RISCV_ARCH-1:0] o_ireg_wdata,
  input  logic [RISCV_ARCH-1:0] i_ireg_rdata,
  output logic                  o_csr_req_valid,
  input  logic                  i_csr_req_ready,
  output logic                  o_csr_req_write,
  output logic [11:0]           o_csr_req_addr,
  output logic [RISCV_ARCH-1:0] o_csr_req_data,
  input  logic                  i_csr_resp_valid,
  output logic                  o_csr_resp_ready,
  input  logic [RISCV_ARCH-1:0] i_csr_resp_data,
  input  logic                  i_csr_resp_exception
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid, once raised, holds with its payload stable until that edge.
  typedef enum logic [2:0] {IDLE, CHECK, GPR, CSR_REQ, CSR_RESP, RESP} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(CSR_TIMEOUT - 1);

  state_t                state, state_n;
  logic                  req_rdy;
  logic                  wr_q;
  logic [15:0]           addr_q;
  logic [RISCV_ARCH-1:0] wdata_q;
  logic [2:0]            size_q;
  logic [7:0]            cnt;
  logic [RISCV_ARCH-1:0] rdata_q;
  logic                  err_q;

  logic size_ok, is_csr, is_gpr, timeout;

  assign size_ok = (size_q == 3'd2) || (size_q == 3'd3);
  assign is_csr  = (addr_q[15:12] == 4'h0);
  assign is_gpr  = (addr_q[15:5] == 11'h080);
  assign timeout = (cnt == TIMEOUT_LAST);

  assign o_dport_req_ready  = req_rdy;
  assign o_dport_rdata      = rdata_q;
  assign o_dport_resp_error = err_q;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n            = state;
    o_ireg_addr        = '0;
    o_ireg_wena        = 1'b0;
    o_ireg_wdata       = '0;
    o_csr_req_valid    = 1'b0;
    o_csr_req_write    = 1'b0;
    o_csr_req_addr     = '0;
    o_csr_req_data     = '0;
    o_csr_resp_ready   = 1'b0;
    o_dport_resp_valid = 1'b0;
    case (state)
      IDLE: if (i_dport_req_valid && req_rdy) state_n = CHECK;
      CHECK: begin
        if (!size_ok || !i_halted || !(is_csr || is_gpr)) state_n = RESP;
        else if (is_gpr)                                  state_n = GPR;
        else                                              state_n = CSR_REQ;
      end
      GPR: begin
        o_ireg_addr  = addr_q[4:0];
        o_ireg_wena  = wr_q && (addr_q[4:0] != 5'd0);
        o_ireg_wdata = wdata_q;
        state_n      = RESP;
      end
      CSR_REQ: begin
        o_csr_req_valid = 1'b1;
        o_csr_req_write = wr_q;
        o_csr_req_addr  = addr_q[11:0];
        o_csr_req_data  = wdata_q;
        if (i_csr_req_ready) state_n = CSR_RESP;
        else if (timeout)    state_n = RESP;
      end
      CSR_RESP: begin
        o_csr_resp_ready = 1'b1;
        if (i_csr_resp_valid || timeout) state_n = RESP;
      end
      RESP: begin
        o_dport_resp_valid = 1'b1;
        if (i_dport_resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Ready is registered so it stays low throughout reset and rises on the first clock after.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      req_rdy <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      req_rdy <= (state_n == IDLE);
      case (state)
        IDLE: if (i_dport_req_valid && req_rdy) begin
          wr_q    <= i_dport_write;
          addr_q  <= i_dport_addr;
          size_q  <= i_dport_size;
          wdata_q <= (i_dport_size == 3'd2) ? RISCV_ARCH'(i_dport_wdata[31:0]) : i_dport_wdata;
        end
        CHECK: begin
          cnt <= '0;
          if (state_n == RESP) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        GPR: begin
          err_q <= 1'b0;
          if (wr_q)                 rdata_q <= '0;
          else if (size_q == 3'd2)  rdata_q <= RISCV_ARCH'(i_ireg_rdata[31:0]);
          else                      rdata_q <= i_ireg_rdata;
        end
        CSR_REQ: begin
          if (i_csr_req_ready) cnt <= '0;
          else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else cnt <= cnt + 8'd1;
        end
        CSR_RESP: begin
          if (i_csr_resp_valid) begin
            err_q <= i_csr_resp_exception;
            if (wr_q)                rdata_q <= '0;
            else if (size_q == 3'd2) rdata_q <= RISCV_ARCH'(i_csr_resp_data[31:0]);
            else                     rdata_q <= i_csr_resp_data;
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else cnt <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dport_responder.sv
// Bench for dport_responder: regfile and CSR environment models, a behavioural
// reference model of the register-access rules, and per-scenario test tasks.
module tb_dport_responder;
  localparam int XLEN = 64;
  localparam int TMO  = 255;

  logic            i_clk, i_nrst;
  logic            i_dport_req_valid, o_dport_req_ready, i_dport_write;
  logic [15:0]     i_dport_addr;
  logic [XLEN-1:0] i_dport_wdata;
  logic [2:0]      i_dport_size;
  logic            o_dport_resp_valid, i_dport_resp_ready, o_dport_resp_error;
  logic [XLEN-1:0] o_dport_rdata;
  logic            i_halted;
  logic [4:0]      o_ireg_addr;
  logic            o_ireg_wena;
  logic [XLEN-1:0] o_ireg_wdata, i_ireg_rdata;
  logic            o_csr_req_valid, i_csr_req_ready, o_csr_req_write;
  logic [11:0]     o_csr_req_addr;
  logic [XLEN-1:0] o_csr_req_data;
  logic            i_csr_resp_valid, o_csr_resp_ready, i_csr_resp_exception;
  logic [XLEN-1:0] i_csr_resp_data;

  dport_responder #(.RISCV_ARCH(XLEN), .CSR_TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_dport_req_valid(i_dport_req_valid), .o_dport_req_ready(o_dport_req_ready),
    .i_dport_write(i_dport_write), .i_dport_addr(i_dport_addr),
    .i_dport_wdata(i_dport_wdata), .i_dport_size(i_dport_size),
    .o_dport_resp_valid(o_dport_resp_valid), .i_dport_resp_ready(i_dport_resp_ready),
    .o_dport_resp_error(o_dport_resp_error), .o_dport_rdata(o_dport_rdata),
    .i_halted(i_halted),
    .o_ireg_addr(o_ireg_addr), .o_ireg_wena(o_ireg_wena),
    .o_ireg_wdata(o_ireg_wdata), .i_ireg_rdata(i_ireg_rdata),
    .o_csr_req_valid(o_csr_req_valid), .i_csr_req_ready(i_csr_req_ready),
    .o_csr_req_write(o_csr_req_write), .o_csr_req_addr(o_csr_req_addr),
    .o_csr_req_data(o_csr_req_data),
    .i_csr_resp_valid(i_csr_resp_valid), .o_csr_resp_ready(o_csr_resp_ready),
    .i_csr_resp_data(i_csr_resp_data), .i_csr_resp_exception(i_csr_resp_exception)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- environment: regfile ----------------
  logic [XLEN-1:0] rf     [32];
  logic [XLEN-1:0] ref_rf [32];
  int              wena_cnt = 0;
  logic [4:0]      last_wena_addr = '0;
  assign i_ireg_rdata = rf[o_ireg_addr];

  // ---------------- environment: CSR unit ----------------
  int              csr_stall = 0;
  bit              csr_no_resp = 1'b0;
  logic [XLEN-1:0] csr_data = '0;
  bit              csr_exc = 1'b0;
  int              csr_hs_cnt = 0;
  int              csr_valid_cycles = 0;
  logic            last_csr_write = 1'b0;
  logic [XLEN-1:0] last_csr_data = '0;
  logic [11:0]     csr_addr_q[$];

  initial begin
    int stall_cnt;
    stall_cnt = 0;
    i_csr_req_ready = 1'b0; i_csr_resp_valid = 1'b0;
    i_csr_resp_data = '0;   i_csr_resp_exception = 1'b0;
    forever begin
      @(posedge i_clk); #2;
      if (o_csr_req_valid) begin
        if (stall_cnt >= csr_stall) i_csr_req_ready = 1'b1;
        else begin i_csr_req_ready = 1'b0; stall_cnt++; end
      end else begin
        i_csr_req_ready = 1'b0; stall_cnt = 0;
      end
      i_csr_resp_valid     = o_csr_resp_ready && !csr_no_resp;
      i_csr_resp_data      = csr_data;
      i_csr_resp_exception = csr_exc;
    end
  end

  always @(negedge i_clk) begin
    if (o_ireg_wena) begin
      rf[o_ireg_addr] = o_ireg_wdata;
      wena_cnt++;
      last_wena_addr = o_ireg_addr;
    end
    if (o_csr_req_valid) begin
      csr_valid_cycles++;
      csr_addr_q.push_back(o_csr_req_addr);
      if (i_csr_req_ready) begin
        csr_hs_cnt++;
        last_csr_write = o_csr_req_write;
        last_csr_data  = o_csr_req_data;
      end
    end
  end

  // ---------------- reference model ----------------
  // kind: 0 = rejected, 1 = GPR, 2 = CSR. Expected latency follows from kind.
  task automatic model(input bit w, input logic [15:0] a, input logic [XLEN-1:0] d,
                       input logic [2:0] s, input bit h,
                       output logic [XLEN-1:0] rd, output logic e, output int kind);
    logic [XLEN-1:0] dz;
    int idx;
    dz = (s == 3'd2) ? {32'h0, d[31:0]} : d;
    rd = '0; e = 1'b1; kind = 0;
    if (!(s == 3'd2 || s == 3'd3) || !h) begin
      kind = 0;
    end else if (a < 16'h1000) begin
      kind = 2; e = csr_exc;
      if (!w) rd = (s == 3'd2) ? {32'h0, csr_data[31:0]} : csr_data;
    end else if (a < 16'h1020) begin
      kind = 1; e = 1'b0; idx = int'(a) - 'h1000;
      if (w) begin
        if (idx != 0) ref_rf[idx] = dz;
      end else begin
        rd = (s == 3'd2) ? {32'h0, ref_rf[idx][31:0]} : ref_rf[idx];
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called and returns at 1 time unit after a rising edge.
  task automatic do_req(input bit w, input logic [15:0] a, input logic [XLEN-1:0] d,
                        input logic [2:0] s,
                        output logic [XLEN-1:0] rd, output logic e, output int lat);
    int guard;
    guard = 0;
    while (!o_dport_req_ready && guard < 50) begin @(posedge i_clk); #1; guard++; end
    i_dport_req_valid = 1'b1; i_dport_write = w; i_dport_addr = a;
    i_dport_wdata = d; i_dport_size = s;
    lat = 0;
    do begin
      @(posedge i_clk); #1;
      i_dport_req_valid = 1'b0;
      lat++;
    end while (!o_dport_resp_valid && lat < 600);
    rd = o_dport_rdata; e = o_dport_resp_error;
    n_checks++;
    if (o_dport_resp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL resp_wait addr=%h got no response within %0d cycles", a, lat);
    end
    i_dport_resp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_dport_resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    i_nrst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++;
    if ({o_dport_req_ready, o_dport_resp_valid, o_dport_resp_error, o_ireg_wena,
         o_csr_req_valid, o_csr_resp_ready} !== 6'b0 || o_dport_rdata !== '0 || o_ireg_addr !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got rdy=%b rv=%b err=%b wena=%b cv=%b crr=%b want all 0",
               o_dport_req_ready, o_dport_resp_valid, o_dport_resp_error, o_ireg_wena,
               o_csr_req_valid, o_csr_resp_ready);
    end
    @(negedge i_clk); i_nrst = 1'b1;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_dport_req_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready got %b want 1", o_dport_req_ready);
    end
  endtask

  task automatic test_gpr;
    logic [XLEN-1:0] rd, erd; logic e, ee; int lat, kind, w0;
    i_halted = 1'b1; w0 = wena_cnt;
    model(1'b1, 16'h1005, 64'h1122334455667788, 3'd3, 1'b1, erd, ee, kind);
    do_req(1'b1, 16'h1005, 64'h1122334455667788, 3'd3, rd, e, lat);
    n_checks++;
    if (wena_cnt !== w0 + 1 || last_wena_addr !== 5'd5) begin
      n_errors++; $display("FAIL gpr_wena got pulses=%0d addr=%0d want 1 at 5", wena_cnt - w0, last_wena_addr);
    end
    n_checks++;
    if (e !== ee || rd !== erd || lat != 3) begin
      n_errors++; $display("FAIL gpr_write got err=%b rd=%h lat=%0d want %b %h 3", e, rd, lat, ee, erd);
    end
    model(1'b0, 16'h1005, '0, 3'd3, 1'b1, erd, ee, kind);
    do_req(1'b0, 16'h1005, '0, 3'd3, rd, e, lat);
    n_checks++;
    if (rd !== 64'h1122334455667788 || e !== 1'b0 || lat != 3) begin
      n_errors++; $display("FAIL gpr_read got rd=%h err=%b lat=%0d want 1122334455667788 0 3", rd, e, lat);
    end
    n_checks++;
    if (rd !== erd) begin n_errors++; $display("FAIL gpr_read_model got %h want %h", rd, erd); end
  endtask

  task automatic test_x0;
    logic [XLEN-1:0] rd; logic e; int lat, w0;
    w0 = wena_cnt;
    do_req(1'b1, 16'h1000, 64'hFF, 3'd3, rd, e, lat);
    n_checks++;
    if (wena_cnt !== w0 || e !== 1'b0) begin
      n_errors++; $display("FAIL x0_write got pulses=%0d err=%b want 0 0", wena_cnt - w0, e);
    end
    do_req(1'b0, 16'h1000, '0, 3'd3, rd, e, lat);
    n_checks++;
    if (rd !== '0 || e !== 1'b0) begin
      n_errors++; $display("FAIL x0_read got rd=%h err=%b want 0 0", rd, e);
    end
  endtask

  task automatic test_csr_stall;
    logic [XLEN-1:0] rd; logic e; int lat, bad;
    csr_stall = 3; csr_data = 64'hDEADBEEF_CAFEF00D; csr_exc = 1'b0; csr_no_resp = 1'b0;
    csr_addr_q.delete();
    do_req(1'b0, 16'h07B1, '0, 3'd2, rd, e, lat);
    n_checks++;
    if (rd !== 64'h00000000CAFEF00D || e !== 1'b0 || lat != 7) begin
      n_errors++; $display("FAIL csr_stall_read got rd=%h err=%b lat=%0d want 00000000cafef00d 0 7", rd, e, lat);
    end
    bad = 0;
    foreach (csr_addr_q[i]) if (csr_addr_q[i] !== 12'h7B1) bad++;
    n_checks++;
    if (csr_addr_q.size() != 4 || bad != 0) begin
      n_errors++; $display("FAIL csr_addr_hold got cycles=%0d bad=%0d want 4 0", csr_addr_q.size(), bad);
    end
    csr_stall = 0;
  endtask

  task automatic test_errors;
    bit          h_t [3] = '{1'b0, 1'b1, 1'b1};
    bit          w_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] a_t [3] = '{16'h1001, 16'h1005, 16'h1020};
    logic [2:0]  s_t [3] = '{3'd3, 3'd1, 3'd3};
    logic [XLEN-1:0] rd; logic e; int lat, w0, c0;
    for (int i = 0; i < 3; i++) begin
      i_halted = h_t[i]; w0 = wena_cnt; c0 = csr_valid_cycles;
      do_req(w_t[i], a_t[i], 64'hA5A5_5A5A_0F0F_F0F0, s_t[i], rd, e, lat);
      n_checks++;
      if (e !== 1'b1 || rd !== '0 || lat != 2 || wena_cnt != w0 || csr_valid_cycles != c0) begin
        n_errors++;
        $display("FAIL err_case%0d got err=%b rd=%h lat=%0d strobes=%0d want 1 0 2 0",
                 i, e, rd, lat, (wena_cnt - w0) + (csr_valid_cycles - c0));
      end
      // Leave rdata non-zero so the next error case proves it is cleared.
      i_halted = 1'b1;
      do_req(1'b0, 16'h1005, '0, 3'd3, rd, e, lat);
    end
  endtask

  task automatic test_random;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] rd, erd, d, dz; logic e, ee; logic [15:0] a; logic [2:0] s;
    bit w, h; int lat, kind, sel, w0, c0, elat;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      a = 16'h1000 + 16'($urandom_range(0, 31));
      else if (sel < 7) a = 16'($urandom_range(0, 'hFFF));
      else              a = 16'h1020 + 16'($urandom_range(0, 'hEFDF));
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 3));
      h = ($urandom_range(0, 7) != 0);
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      dz = (s == 3'd2) ? {32'h0, d[31:0]} : d;
      csr_data = {$urandom, $urandom}; csr_exc = ($urandom_range(0, 3) == 0);
      csr_stall = $urandom_range(0, 3);
      i_halted = h; w0 = wena_cnt; c0 = csr_hs_cnt;
      model(w, a, d, s, h, erd, ee, kind);
      exp_q.push_back(erd);
      do_req(w, a, d, s, rd, e, lat);
      elat = (kind == 0) ? 2 : (kind == 1) ? 3 : 4 + csr_stall;
      erd = exp_q.pop_front();
      n_checks++;
      if (rd !== erd || e !== ee || lat != elat) begin
        n_errors++;
        $display("FAIL rand%0d a=%h w=%b s=%0d h=%b got rd=%h err=%b lat=%0d want %h %b %0d",
                 n, a, w, s, h, rd, e, lat, erd, ee, elat);
      end
      n_checks++;
      if (wena_cnt - w0 != ((kind == 1 && w && a != 16'h1000) ? 1 : 0) ||
          csr_hs_cnt - c0 != ((kind == 2) ? 1 : 0)) begin
        n_errors++;
        $display("FAIL rand%0d_strobes got wena=%0d csr=%0d kind=%0d", n, wena_cnt - w0, csr_hs_cnt - c0, kind);
      end
      if (kind == 2 && w) begin
        n_checks++;
        if (last_csr_write !== 1'b1 || last_csr_data !== dz) begin
          n_errors++;
          $display("FAIL rand%0d_csr_wdata got w=%b d=%h want 1 %h", n, last_csr_write, last_csr_data, dz);
        end
      end
    end
    csr_stall = 0; csr_exc = 1'b0; i_halted = 1'b1;
  endtask

  task automatic test_timeout;
    logic [XLEN-1:0] rd, erd; logic e, ee; int lat, kind, c0;
    i_halted = 1'b1;
    do_req(1'b0, 16'h1005, '0, 3'd3, rd, e, lat);
    csr_no_resp = 1'b1; c0 = csr_hs_cnt;
    do_req(1'b0, 16'h0300, '0, 3'd3, rd, e, lat);
    n_checks++;
    if (e !== 1'b1 || rd !== '0 || lat != 3 + TMO || csr_hs_cnt != c0 + 1) begin
      n_errors++; $display("FAIL csr_resp_timeout got err=%b rd=%h lat=%0d want 1 0 %0d", e, rd, lat, 3 + TMO);
    end
    csr_no_resp = 1'b0; csr_stall = 100000; c0 = csr_hs_cnt;
    do_req(1'b1, 16'h0340, 64'h1234, 3'd3, rd, e, lat);
    n_checks++;
    if (e !== 1'b1 || lat != 2 + TMO || csr_hs_cnt != c0) begin
      n_errors++; $display("FAIL csr_req_timeout got err=%b lat=%0d hs=%0d want 1 %0d 0", e, lat, csr_hs_cnt - c0, 2 + TMO);
    end
    csr_stall = 0;
    model(1'b0, 16'h1003, '0, 3'd3, 1'b1, erd, ee, kind);
    do_req(1'b0, 16'h1003, '0, 3'd3, rd, e, lat);
    n_checks++;
    if (rd !== erd || e !== 1'b0 || lat != 3) begin
      n_errors++; $display("FAIL after_timeout_gpr got rd=%h err=%b lat=%0d want %h 0 3", rd, e, lat, erd);
    end
  endtask

  task automatic test_back_to_back;
    logic [XLEN-1:0] erd_a, erd_b; logic ee; int kind, lat;
    i_halted = 1'b1;
    model(1'b0, 16'h1005, '0, 3'd3, 1'b1, erd_a, ee, kind);
    model(1'b0, 16'h1007, '0, 3'd3, 1'b1, erd_b, ee, kind);
    i_dport_req_valid = 1'b1; i_dport_write = 1'b0; i_dport_addr = 16'h1005; i_dport_size = 3'd3;
    @(posedge i_clk); #1;
    i_dport_addr = 16'h1007;
    lat = 0;
    while (!o_dport_resp_valid && lat < 20) begin @(posedge i_clk); #1; lat++; end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (o_dport_resp_valid !== 1'b1 || o_dport_rdata !== erd_a || o_dport_resp_error !== 1'b0 ||
          o_dport_req_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold%0d got rv=%b rd=%h err=%b rdy=%b want 1 %h 0 0", i,
                 o_dport_resp_valid, o_dport_rdata, o_dport_resp_error, o_dport_req_ready, erd_a);
      end
      @(posedge i_clk); #1;
    end
    i_dport_resp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_dport_resp_ready = 1'b0;
    n_checks++;
    if (o_dport_req_ready !== 1'b1 || o_dport_resp_valid !== 1'b0) begin
      n_errors++; $display("FAIL b2b_ready got rdy=%b rv=%b want 1 0", o_dport_req_ready, o_dport_resp_valid);
    end
    lat = 0;
    do begin @(posedge i_clk); #1; i_dport_req_valid = 1'b0; lat++; end
    while (!o_dport_resp_valid && lat < 20);
    n_checks++;
    if (o_dport_rdata !== erd_b || lat != 3) begin
      n_errors++; $display("FAIL b2b_second got rd=%h lat=%0d want %h 3", o_dport_rdata, lat, erd_b);
    end
    i_dport_resp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_dport_resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [XLEN-1:0] rd, erd; logic e, ee; int lat, kind, guard, seen;
    csr_stall = 100000;
    i_dport_req_valid = 1'b1; i_dport_write = 1'b1; i_dport_addr = 16'h0305;
    i_dport_wdata = 64'h55; i_dport_size = 3'd3;
    @(posedge i_clk); #1;
    i_dport_req_valid = 1'b0;
    guard = 0;
    while (!o_csr_req_valid && guard < 10) begin @(posedge i_clk); #1; guard++; end
    n_checks++;
    if (o_csr_req_valid !== 1'b1) begin n_errors++; $display("FAIL mid_csr_valid got 0 want 1"); end
    #1 i_nrst = 1'b0;
    #1;
    n_checks++;
    if (o_csr_req_valid !== 1'b0 || o_dport_resp_valid !== 1'b0 || o_dport_req_ready !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset got cv=%b rv=%b rdy=%b want 0 0 0",
                           o_csr_req_valid, o_dport_resp_valid, o_dport_req_ready);
    end
    @(negedge i_clk); i_nrst = 1'b1; csr_stall = 0;
    seen = 0;
    repeat (6) begin @(posedge i_clk); #1; if (o_dport_resp_valid || o_csr_req_valid) seen++; end
    n_checks++;
    if (seen != 0 || o_dport_req_ready !== 1'b1) begin
      n_errors++; $display("FAIL mid_discard got activity=%0d rdy=%b want 0 1", seen, o_dport_req_ready);
    end
    model(1'b0, 16'h1005, '0, 3'd3, 1'b1, erd, ee, kind);
    do_req(1'b0, 16'h1005, '0, 3'd3, rd, e, lat);
    n_checks++;
    if (rd !== erd || e !== 1'b0) begin
      n_errors++; $display("FAIL mid_after got rd=%h err=%b want %h 0", rd, e, erd);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i] = (i == 0) ? '0 : {$urandom, $urandom};
      ref_rf[i] = rf[i];
    end
    i_nrst = 1'b0; i_dport_req_valid = 1'b0; i_dport_write = 1'b0; i_dport_addr = '0;
    i_dport_wdata = '0; i_dport_size = 3'd3; i_dport_resp_ready = 1'b0; i_halted = 1'b1;
    test_reset();
    test_gpr();
    test_x0();
    test_csr_stall();
    test_errors();
    test_random();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
